// File: rtl/mem_defines.sv
// Shared types and constants for the memory responder.
//   mem_state_e      : request engine state (idle, counting latency, response cycle)
//   MEM_SIZE_B/H/W   : LSU access size encodings
//   mem_req_t        : one latched request (address, size, store flag, data, lane mask)
//   size_misaligned  : true when an access is misaligned for its size
package mem_defines;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == MEM_SIZE_H) && lo[0]) || ((size == MEM_SIZE_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_bank.sv
// Single-port DEPTH x 32 storage with byte-lane write enables and a registered
// read port. No reset: contents survive a system reset.
//   clk_i   : clock
//   re_i    : read enable, rdata_o updates on the next edge
//   we_i    : byte-lane write enables
//   addr_i  : word index
//   wdata_i : write data, lane-aligned
//   rdata_o : registered read data, holds until the next read
module mem_bank #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU fetch (IFU) and load/store (LSU) ports.
// Each port has one pending slot; a single engine serves one request at a time
// with LSU priority and answers with a one-cycle respValid pulse LATENCY+1
// cycles after an uncontended request.
//   clock, reset          : clock, asynchronous active-low reset
//   io_ifu_reqValid/addr  : fetch request pulse and byte address
//   io_ifu_respValid/rdata: fetch response pulse and aligned word
//   io_lsu_reqValid/addr/size/wen/wdata/wmask : load/store request
//   io_lsu_respValid/rdata: load/store response pulse, rdata 0 for stores
//   err                   : sticky error (range, alignment, size, double request)
module mem_responder
    import mem_defines::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_ifu_reqValid,
    input  logic [31:0] io_ifu_addr,
    output logic        io_ifu_respValid,
    output logic [31:0] io_ifu_rdata,
    input  logic        io_lsu_reqValid,
    input  logic [31:0] io_lsu_addr,
    input  logic [1:0]  io_lsu_size,
    input  logic        io_lsu_wen,
    input  logic [31:0] io_lsu_wdata,
    input  logic [3:0]  io_lsu_wmask,
    output logic        io_lsu_respValid,
    output logic [31:0] io_lsu_rdata,
    output logic        err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE};
        return (a >= BASE) && (off < LIMIT);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE) >> 2);
    endfunction

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mem_req_t      lsu_slot_q, lsu_slot_d, ifu_slot_q, ifu_slot_d;
    logic          lsu_pend_q, lsu_pend_d, ifu_pend_q, ifu_pend_d;  // slot holds ungranted req
    logic          lsu_out_q, lsu_out_d, ifu_out_q, ifu_out_d;      // accepted, not yet answered
    mem_req_t      act_q, act_d;
    logic          act_lsu_q, act_lsu_d, act_ok_q, act_ok_d;
    logic          lsu_resp_q, lsu_resp_d, ifu_resp_q, ifu_resp_d;
    logic [31:0]   lsu_rdata_q, lsu_rdata_d, ifu_rdata_q, ifu_rdata_d;
    logic          err_q, err_d;

    mem_req_t      lsu_in, ifu_in, lsu_cand, ifu_cand, grant_req;
    logic          lsu_accept, ifu_accept, lsu_avail, ifu_avail;
    logic          can_grant, grant_lsu, grant_ifu, access;
    logic          bank_re;
    logic [3:0]    bank_we;
    logic [AW-1:0] bank_addr;
    logic [31:0]   bank_rdata, resp_data;
    logic          unused_size;

    assign unused_size = ^act_q.size;

    // Request decode and arbitration; a same-cycle pulse is as good as a full slot.
    always_comb begin
        lsu_in       = '0;
        lsu_in.addr  = io_lsu_addr;
        lsu_in.size  = io_lsu_size;
        lsu_in.wen   = io_lsu_wen;
        lsu_in.wdata = io_lsu_wdata;
        lsu_in.wmask = io_lsu_wmask;
        ifu_in       = '0;
        ifu_in.addr  = io_ifu_addr;
        ifu_in.size  = MEM_SIZE_W;

        lsu_accept = io_lsu_reqValid && !lsu_out_q;
        ifu_accept = io_ifu_reqValid && !ifu_out_q;
        lsu_avail  = lsu_pend_q || lsu_accept;
        ifu_avail  = ifu_pend_q || ifu_accept;
        lsu_cand   = lsu_pend_q ? lsu_slot_q : lsu_in;
        ifu_cand   = ifu_pend_q ? ifu_slot_q : ifu_in;

        can_grant  = (state_q == MEM_IDLE) || (state_q == MEM_RESP);
        grant_lsu  = can_grant && lsu_avail;
        grant_ifu  = can_grant && !lsu_avail && ifu_avail;
        grant_req  = grant_lsu ? lsu_cand : ifu_cand;
        access     = (state_q == MEM_BUSY) && (cnt_q == '0);

        // Loads read the bank at grant so the data is ready at the access edge;
        // stores write at the access edge. The two never coincide.
        bank_addr  = access ? word_idx(act_q.addr) : word_idx(grant_req.addr);
        bank_re    = (grant_lsu || grant_ifu) && !grant_req.wen && in_range(grant_req.addr);
        bank_we    = (access && act_q.wen && act_ok_q) ? act_q.wmask : 4'b0000;
        resp_data  = (act_ok_q && !act_q.wen) ? bank_rdata : 32'h0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lsu_slot_d  = lsu_slot_q;
        ifu_slot_d  = ifu_slot_q;
        lsu_pend_d  = lsu_pend_q;
        ifu_pend_d  = ifu_pend_q;
        lsu_out_d   = lsu_out_q;
        ifu_out_d   = ifu_out_q;
        act_d       = act_q;
        act_lsu_d   = act_lsu_q;
        act_ok_d    = act_ok_q;
        lsu_resp_d  = 1'b0;
        ifu_resp_d  = 1'b0;
        lsu_rdata_d = lsu_rdata_q;
        ifu_rdata_d = ifu_rdata_q;
        err_d       = err_q;

        case (state_q)
            MEM_IDLE, MEM_RESP: begin
                if (grant_lsu || grant_ifu) begin
                    state_d = MEM_BUSY;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_BUSY: begin
                if (access) begin
                    state_d = MEM_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = MEM_IDLE;
        endcase

        if (grant_lsu || grant_ifu) begin
            act_d     = grant_req;
            act_lsu_d = grant_lsu;
            act_ok_d  = in_range(grant_req.addr);
        end

        if (access) begin
            if (act_lsu_q) begin
                lsu_resp_d  = 1'b1;
                lsu_rdata_d = resp_data;
                lsu_out_d   = 1'b0;
            end else begin
                ifu_resp_d  = 1'b1;
                ifu_rdata_d = resp_data;
                ifu_out_d   = 1'b0;
            end
        end

        if (grant_lsu && lsu_pend_q) lsu_pend_d = 1'b0;
        if (grant_ifu && ifu_pend_q) ifu_pend_d = 1'b0;
        if (lsu_accept) begin
            lsu_out_d = 1'b1;
            if (!grant_lsu) begin
                lsu_pend_d = 1'b1;
                lsu_slot_d = lsu_in;
            end
        end
        if (ifu_accept) begin
            ifu_out_d = 1'b1;
            if (!grant_ifu) begin
                ifu_pend_d = 1'b1;
                ifu_slot_d = ifu_in;
            end
        end

        if (io_lsu_reqValid && lsu_out_q) err_d = 1'b1;
        if (io_ifu_reqValid && ifu_out_q) err_d = 1'b1;
        if (lsu_accept && (!in_range(io_lsu_addr) || (io_lsu_size == 2'd3) ||
                           size_misaligned(io_lsu_size, io_lsu_addr[1:0]))) begin
            err_d = 1'b1;
        end
        if (ifu_accept && !in_range(io_ifu_addr)) err_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= MEM_IDLE;
            cnt_q       <= '0;
            lsu_slot_q  <= '0;
            ifu_slot_q  <= '0;
            lsu_pend_q  <= 1'b0;
            ifu_pend_q  <= 1'b0;
            lsu_out_q   <= 1'b0;
            ifu_out_q   <= 1'b0;
            act_q       <= '0;
            act_lsu_q   <= 1'b0;
            act_ok_q    <= 1'b0;
            lsu_resp_q  <= 1'b0;
            ifu_resp_q  <= 1'b0;
            lsu_rdata_q <= '0;
            ifu_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lsu_slot_q  <= lsu_slot_d;
            ifu_slot_q  <= ifu_slot_d;
            lsu_pend_q  <= lsu_pend_d;
            ifu_pend_q  <= ifu_pend_d;
            lsu_out_q   <= lsu_out_d;
            ifu_out_q   <= ifu_out_d;
            act_q       <= act_d;
            act_lsu_q   <= act_lsu_d;
            act_ok_q    <= act_ok_d;
            lsu_resp_q  <= lsu_resp_d;
            ifu_resp_q  <= ifu_resp_d;
            lsu_rdata_q <= lsu_rdata_d;
            ifu_rdata_q <= ifu_rdata_d;
            err_q       <= err_d;
        end
    end

    mem_bank #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_bank (
        .clk_i  (clock),
        .re_i   (bank_re),
        .we_i   (bank_we),
        .addr_i (bank_addr),
        .wdata_i(act_q.wdata),
        .rdata_o(bank_rdata)
    );

    assign io_lsu_respValid = lsu_resp_q;
    assign io_lsu_rdata     = lsu_rdata_q;
    assign io_ifu_respValid = ifu_resp_q;
    assign io_ifu_rdata     = ifu_rdata_q;
    assign err              = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected responses computed
// from a word-array model; a negedge monitor pops and compares on each respValid.
module tb_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_ifu_reqValid = 1'b0;
    logic [31:0] io_ifu_addr = '0;
    logic        io_ifu_respValid;
    logic [31:0] io_ifu_rdata;
    logic        io_lsu_reqValid = 1'b0;
    logic [31:0] io_lsu_addr = '0;
    logic [1:0]  io_lsu_size = '0;
    logic        io_lsu_wen = 1'b0;
    logic [31:0] io_lsu_wdata = '0;
    logic [3:0]  io_lsu_wmask = '0;
    logic        io_lsu_respValid;
    logic [31:0] io_lsu_rdata;
    logic        err;

    mem_responder #(
        .DEPTH  (DEPTH),
        .BASE   (BASE),
        .LATENCY(LAT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_ifu_reqValid (io_ifu_reqValid),
        .io_ifu_addr     (io_ifu_addr),
        .io_ifu_respValid(io_ifu_respValid),
        .io_ifu_rdata    (io_ifu_rdata),
        .io_lsu_reqValid (io_lsu_reqValid),
        .io_lsu_addr     (io_lsu_addr),
        .io_lsu_size     (io_lsu_size),
        .io_lsu_wen      (io_lsu_wen),
        .io_lsu_wdata    (io_lsu_wdata),
        .io_lsu_wmask    (io_lsu_wmask),
        .io_lsu_respValid(io_lsu_respValid),
        .io_lsu_rdata    (io_lsu_rdata),
        .err             (err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        int          cycle;
        logic        err;
    } exp_t;

    exp_t        lq[$];
    exp_t        iq[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] mem_m [int];
    logic        err_m = 1'b0;
    logic [31:0] last_l = '0;
    logic [31:0] last_i = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < DEPTH);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic bit m_misaligned(input logic [1:0] s, input logic [31:0] a);
        return ((s == 2'd1) && (a % 2 != 0)) || ((s == 2'd2) && (a % 4 != 0));
    endfunction

    // Test word set: first 16 words plus the last 4.
    function automatic int set_idx(input int i);
        return (i < 16) ? i : (DEPTH - 20 + i);
    endfunction

    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset) begin
            check("rst_lsu_resp", 32'(io_lsu_respValid), 32'h0);
            check("rst_ifu_resp", 32'(io_ifu_respValid), 32'h0);
            check("rst_lsu_rdata", io_lsu_rdata, 32'h0);
            check("rst_ifu_rdata", io_ifu_rdata, 32'h0);
            check("rst_err", 32'(err), 32'h0);
            last_l = '0;
            last_i = '0;
        end else begin
            if (io_lsu_respValid || io_ifu_respValid) begin
                check("one_resp_at_a_time", 32'(io_lsu_respValid && io_ifu_respValid), 32'h0);
            end
            if (io_lsu_respValid) begin
                if (lq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL lsu_unexpected: got respValid=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = lq.pop_front();
                    check("lsu_rdata", io_lsu_rdata, e.rdata);
                    check("lsu_cycle", 32'(cyc), 32'(e.cycle));
                    check("lsu_err", 32'(err), 32'(e.err));
                    last_l = e.rdata;
                end
            end else begin
                check("lsu_rdata_hold", io_lsu_rdata, last_l);
            end
            if (io_ifu_respValid) begin
                if (iq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ifu_unexpected: got respValid=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = iq.pop_front();
                    check("ifu_rdata", io_ifu_rdata, e.rdata);
                    check("ifu_cycle", 32'(cyc), 32'(e.cycle));
                    check("ifu_err", 32'(err), 32'(e.err));
                    last_i = e.rdata;
                end
            end else begin
                check("ifu_rdata_hold", io_ifu_rdata, last_i);
            end
        end
    end

    // One round: optional LSU and IFU requests in the same cycle, optional second
    // IFU pulse a cycle later, then wait until every expected response arrived.
    task automatic round(input bit le, input logic [31:0] la, input logic [1:0] ls,
                         input bit lw, input logic [31:0] ld, input logic [3:0] lm,
                         input bit ie, input logic [31:0] ia, input bit idbl, input bit now);
        exp_t        el;
        exp_t        ei;
        int          t;
        logic [31:0] bm;
        if (!now) begin
            @(posedge clock);
            #1;
        end
        t = cyc;
        if (le && (!m_in_range(la) || m_misaligned(ls, la) || ls == 2'd3)) err_m = 1'b1;
        if (ie && !m_in_range(ia)) err_m = 1'b1;
        if (ie && idbl) err_m = 1'b1;
        if (le) begin
            el.rdata = '0;
            if (m_in_range(la)) begin
                if (lw) begin
                    bm = {{8{lm[3]}}, {8{lm[2]}}, {8{lm[1]}}, {8{lm[0]}}};
                    mem_m[m_idx(la)] = (mem_m[m_idx(la)] & ~bm) | (ld & bm);
                end else begin
                    el.rdata = mem_m[m_idx(la)];
                end
            end
            el.cycle = t + LAT + 1;
            el.err   = err_m;
            lq.push_back(el);
        end
        if (ie) begin
            ei.rdata = m_in_range(ia) ? mem_m[m_idx(ia)] : 32'h0;
            ei.cycle = le ? (t + 2 * LAT + 2) : (t + LAT + 1);
            ei.err   = err_m;
            iq.push_back(ei);
        end
        io_lsu_reqValid = le;
        io_lsu_addr     = la;
        io_lsu_size     = ls;
        io_lsu_wen      = lw;
        io_lsu_wdata    = ld;
        io_lsu_wmask    = lm;
        io_ifu_reqValid = ie;
        io_ifu_addr     = ia;
        @(posedge clock);
        #1;
        io_lsu_reqValid = 1'b0;
        io_ifu_reqValid = ie && idbl;
        @(posedge clock);
        #1;
        io_ifu_reqValid = 1'b0;
        for (int k = 0; k < 40 && (lq.size() != 0 || iq.size() != 0); k++) @(posedge clock);
        if (lq.size() != 0 || iq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL round_timeout: got %0d lsu / %0d ifu responses missing, expected 0",
                     lq.size(), iq.size());
            lq.delete();
            iq.delete();
        end
    endtask

    task automatic apply_reset(input int n);
        @(posedge clock);
        #1;
        reset = 1'b0;
        err_m = 1'b0;
        lq.delete();
        iq.delete();
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            round(1, BASE + 32'(4 * set_idx(i)), 2'd2, 1, $urandom, 4'hF, 0, '0, 0, 0);
        end

        // Store then fetch.
        round(1, BASE + 32'h10, 2'd2, 1, 32'h0010_0073, 4'hF, 0, '0, 0, 0);
        round(0, '0, 2'd0, 0, '0, 4'h0, 1, BASE + 32'h10, 0, 0);
        @(negedge clock);
        check("fetch_after_store", io_ifu_rdata, 32'h0010_0073);

        // Byte store into a preloaded word.
        round(1, BASE, 2'd2, 1, 32'h1122_3344, 4'hF, 0, '0, 0, 0);
        round(1, BASE + 32'h1, 2'd0, 1, 32'h0000_AA00, 4'b0010, 0, '0, 0, 0);
        round(1, BASE, 2'd2, 0, '0, 4'h0, 0, '0, 0, 0);
        @(negedge clock);
        check("byte_store_reload", io_lsu_rdata, 32'h1122_AA44);

        // Simultaneous requests.
        round(1, BASE + 32'h10, 2'd2, 0, '0, 4'h0, 1, BASE, 0, 0);

        for (int r = 0; r < 150; r++) begin
            bit          le;
            bit          ie;
            bit          lw;
            logic [1:0]  ls;
            int          off;
            logic [3:0]  lm;
            logic [31:0] la;
            logic [31:0] ia;
            le  = ($urandom_range(0, 1) == 1);
            ie  = ($urandom_range(0, 1) == 1);
            if (!le && !ie) le = 1'b1;
            ls  = 2'($urandom_range(0, 2));
            lw  = ($urandom_range(0, 1) == 1);
            case (ls)
                2'd0:    off = int'($urandom_range(0, 3));
                2'd1:    off = 2 * int'($urandom_range(0, 1));
                default: off = 0;
            endcase
            la  = BASE + 32'(4 * set_idx(int'($urandom_range(0, 19)))) + 32'(off);
            ia  = BASE + 32'(4 * set_idx(int'($urandom_range(0, 19))));
            lm  = 4'h0;
            if (lw) lm = (ls == 2'd0) ? (4'b0001 << off) : (ls == 2'd1) ? (4'b0011 << off) : 4'hF;
            round(le, la, ls, lw, $urandom, lm, ie, ia, 0, 0);
        end
        @(negedge clock);
        check("no_err_after_random", 32'(err), 32'h0);

        // Misaligned halfword load executes on the aligned word.
        round(1, BASE + 32'h3, 2'd1, 0, '0, 4'h0, 0, '0, 0, 0);
        @(negedge clock);
        check("misaligned_err", 32'(err), 32'h1);

        // Out of range: load returns 0, store is dropped; reset clears err first.
        apply_reset(2);
        round(1, BASE + 32'h1000, 2'd2, 0, '0, 4'h0, 0, '0, 0, 1);
        round(1, BASE + 32'h1000, 2'd2, 1, 32'hDEAD_BEEF, 4'hF, 0, '0, 0, 0);
        round(1, BASE, 2'd2, 0, '0, 4'h0, 1, BASE + 32'hFFC, 0, 0);
        round(1, 32'h7FFF_FFFC, 2'd2, 0, '0, 4'h0, 0, '0, 0, 0);
        @(negedge clock);
        check("oor_err", 32'(err), 32'h1);

        // Second IFU pulse before the first answer: one response, err set.
        apply_reset(2);
        round(0, '0, 2'd0, 0, '0, 4'h0, 1, BASE + 32'h10, 1, 1);
        @(negedge clock);
        check("double_req_err", 32'(err), 32'h1);

        // Size 3 flags an error but still reads the word.
        apply_reset(2);
        round(1, BASE + 32'h8, 2'd3, 0, '0, 4'h0, 0, '0, 0, 1);
        @(negedge clock);
        check("size3_err", 32'(err), 32'h1);

        // Reset while the engine is busy: no response, outputs cleared.
        round(1, BASE + 32'h10, 2'd2, 0, '0, 4'h0, 1, BASE + 32'h4, 0, 0);
        @(posedge clock);
        #1;
        io_lsu_reqValid = 1'b1;
        io_lsu_addr     = BASE + 32'h14;
        io_lsu_size     = 2'd2;
        io_lsu_wen      = 1'b0;
        @(posedge clock);
        #1;
        io_lsu_reqValid = 1'b0;
        reset = 1'b0;
        err_m = 1'b0;
        lq.delete();
        iq.delete();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        round(1, BASE + 32'h10, 2'd2, 0, '0, 4'h0, 0, '0, 0, 1);
        @(negedge clock);
        check("post_reset_err", 32'(err), 32'h0);

        repeat (10) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's two request/response ports (instruction fetch and load/store). It accepts single-cycle request pulses on both ports and arbitrates them onto one internal word-organised memory with byte-write masks. It returns one single-cycle response pulse per request after a programmable latency. It is the SoC counterpart of the CPU's fetch and load/store initiators, and replaces direct testbench-modelled memory.

## Interface
Parameters:
- `DEPTH`, 1024: memory size in 32-bit words; must be a power of two.
- `BASE`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 2: cycles from grant to response; must be ≥1.

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `io_ifu_reqValid`  in  1  single-cycle fetch request pulse.
- `io_ifu_addr`  in  32  fetch byte address, sampled with reqValid.
- `io_ifu_respValid`  out  1  single-cycle fetch response pulse.
- `io_ifu_rdata`  out  32  fetched word, valid while respValid is high.
- `io_lsu_reqValid`  in  1  single-cycle load/store request pulse.
- `io_lsu_addr`  in  32  byte address.
- `io_lsu_size`  in  2  access size: 0=byte, 1=half, 2=word.
- `io_lsu_wen`  in  1  1=store, 0=load.
- `io_lsu_wdata`  in  32  store data, already lane-aligned.
- `io_lsu_wmask`  in  4  byte-lane write enables.
- `io_lsu_respValid`  out  1  single-cycle load/store response pulse.
- `io_lsu_rdata`  out  32  loaded aligned word; 0 for stores.
- `err`  out  1  sticky error flag; cleared only by reset.

## Operation
- Each port holds one pending slot. A reqValid pulse latches that port's request fields into its slot.
- Word index = (addr − BASE) >> 2. An address is in range when BASE ≤ addr < BASE + 4·DEPTH.
- Reads return the full aligned word. addr[1:0] and size do not shift or extend the data; the CPU's LSU does that.
- Stores write the lanes selected by wmask at the word index and leave all other lanes unchanged.
- States:
  - IDLE: on any request (pending slot or same-cycle incoming pulse), grant it, load counter = LATENCY−1, go to BUSY.
  - BUSY: decrement the counter. At counter 0, perform the access, drive the response, and go to RESP.
  - RESP: response cycle. Grant the next pending request in this same cycle if one exists (go to BUSY); otherwise go to IDLE.
- Arbitration: LSU has fixed priority over IFU when both are pending.
- `err` is set by any of:
  - an out-of-range address on either port (read returns 32'h0, write is dropped, response still issued);
  - an LSU access misaligned for its size (size 1 with addr[0]=1; size 2 with addr[1:0]≠0), which still executes on the aligned word;
  - reqValid on a port whose previous request is not yet answered (the new request is ignored);
  - size 3.
- Reset (asserted at any time, including mid-access):
  - clears both pending slots, the counter, state (→IDLE), both respValid outputs, both rdata outputs (→0) and `err`;
  - no response is issued for requests in flight;
  - memory contents are not reset.

## Timing
- Uncontended request with reqValid high in cycle T: respValid is high in cycle T+LATENCY+1, for exactly one cycle.
- Simultaneous requests in cycle T: LSU responds at T+LATENCY+1, IFU at T+2·LATENCY+2.
- respValid and rdata are registered outputs. rdata holds its value after respValid falls until the next response on the same port.
- A store's data is visible to any request granted after that store's response cycle.
- Reset deassertion: the first request is accepted in the first cycle `reset` is high.

## Structure
- Package `mem_defines`:
  - state enum {MEM_IDLE, MEM_BUSY, MEM_RESP};
  - size constants MEM_SIZE_B/H/W;
  - request struct {addr, size, wen, wdata, wmask}.
- Sub-module `mem_bank`: single-port DEPTH×32 array with byte-lane write enables and a registered read port. It has no reset.

## Test plan
- Store then fetch: LSU store addr 32'h8000_0010, wdata 32'h0010_0073, wmask 4'hF, LATENCY=2 → lsu respValid 3 cycles after req. A subsequent IFU fetch of 32'h8000_0010 → rdata 32'h0010_0073, err=0.
- Byte store: word preloaded 32'h1122_3344; store wdata 32'h0000_AA00, wmask 4'b0010, size 0, addr 32'h8000_0001 → reload returns 32'h1122_AA44.
- Simultaneous requests: IFU and LSU reqValid in the same cycle T → LSU respValid at T+3, IFU respValid at T+6, never both high in one cycle.
- Out of range: LSU load at 32'h8000_1000 (DEPTH=1024) → response with rdata 0, err=1. A store to the same address leaves memory unchanged.
- Misalignment and double request: halfword load at 32'h8000_0003 → err=1, returns the word at 32'h8000_0000. A second IFU reqValid before the first response → only one IFU response, err=1.
- Reset mid-access: reset low during BUSY → no respValid, outputs 0, err 0. After release, a load returns the previously stored data.
